// File: rtl/cpu_trace_buffer.sv
// Trace capture FIFO on the CPU observation port: one entry per pc change while armed.
// Optional feature macro TRACE_TIMESTAMP_EN adds a 16-bit CAPTURE-cycle stamp to each entry.
module cpu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
`ifdef TRACE_TIMESTAMP_EN
    parameter int ENTRY_W = 112
`else
    parameter int ENTRY_W = 96
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic [31:0]        Alures,
    input  logic [31:0]        registerOut,
    input  logic               halt,
    input  logic               arm,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [ADDR_W:0]    count,
    output logic               capturing,
    output logic               done,
    output logic               halt_stop
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t             state, state_next;
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic [31:0]        pc_q;
    logic               first;
    logic               halt_stop_next;
    logic               qual, do_rd, do_wr;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   ts <= '0;
        else if (arm)               ts <= '0;
        else if (state == CAPTURE)  ts <= ts + 16'd1;
    end

    assign entry = {ts, pc, Alures, registerOut};
`else
    assign entry = {pc, Alures, registerOut};
`endif

    // Read port: a transfer happens when rd_valid & rd_ready; rd_data is the oldest
    // entry (show-ahead) and is only meaningful while rd_valid is high. arm kills the read.
    assign rd_valid  = (count != '0);
    assign rd_data   = mem[rd_ptr];
    assign capturing = (state == CAPTURE);
    assign done      = (state == DONE);

    always_comb begin
        state_next     = state;
        halt_stop_next = halt_stop;
        do_rd = rd_valid && rd_ready && !arm;
        qual  = (state == CAPTURE) && !arm && (first || (pc != pc_q));
        do_wr = qual && ((count < FULL_CNT) || do_rd);
        if (arm) begin
            state_next     = CAPTURE;
            halt_stop_next = 1'b0;
        end else if (state == CAPTURE) begin
            if (halt) begin
                state_next     = DONE;
                halt_stop_next = 1'b1;
            end else if (do_wr && !do_rd && (count == LAST_CNT)) begin
                state_next     = DONE;
                halt_stop_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            halt_stop <= 1'b0;
            pc_q      <= '0;
            first     <= 1'b0;
        end else begin
            state     <= state_next;
            halt_stop <= halt_stop_next;
            pc_q      <= pc;
            // first stays set through the arm cycle so the first CAPTURE cycle always records
            if (arm)                   first <= 1'b1;
            else if (state == CAPTURE) first <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (arm) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= entry;
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the trace buffer.
module tb_cpu_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 112;
`else
    localparam int ENTRY_W = 96;
`endif
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]        pc = '0, alures = '0, register_out = '0;
    logic               halt = 1'b0, arm = 1'b0, rd_ready = 1'b0;
    logic               rd_valid, capturing, done, halt_stop;
    logic [ENTRY_W-1:0] rd_data;
    logic [4:0]         count;

    cpu_trace_buffer dut (
        .clk(clk), .rst(rst), .pc(pc), .Alures(alures), .registerOut(register_out),
        .halt(halt), .arm(arm), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .count(count), .capturing(capturing), .done(done),
        .halt_stop(halt_stop)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [ENTRY_W-1:0] exp_q[$];
    bit                 m_cap, m_done, m_hs, m_first;
    logic [31:0]        m_pcq;
    int                 m_ts;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cap = 0; m_done = 0; m_hs = 0; m_first = 0; m_pcq = '0; m_ts = 0;
    endtask

    function automatic logic [ENTRY_W-1:0] make_entry();
        logic [ENTRY_W-1:0] e;
        logic [15:0]        t;
        t = 16'(m_ts);
`ifdef TRACE_TIMESTAMP_EN
        e = {t, pc, alures, register_out};
`else
        e = {pc, alures, register_out};
        if (t == 16'hFFFF) e = {pc, alures, register_out};
`endif
        return e;
    endfunction

    // One clock of the reference behaviour, using the inputs as driven before the edge.
    task automatic model_step();
        bit rd;
        bit pushed;
        pushed = 0;
        rd = (exp_q.size() != 0) && rd_ready && !arm;
        if (arm) begin
            exp_q.delete();
            m_cap = 1; m_done = 0; m_hs = 0; m_first = 1; m_ts = 0; m_pcq = pc;
            return;
        end
        if (rd) void'(exp_q.pop_front());
        if (m_cap) begin
            if ((m_first || pc != m_pcq) && exp_q.size() < DEPTH) begin
                exp_q.push_back(make_entry());
                pushed = 1;
            end
            if (halt) begin
                m_cap = 0; m_done = 1; m_hs = 1;
            end else if (pushed && exp_q.size() == DEPTH) begin
                m_cap = 0; m_done = 1; m_hs = 0;
            end
            m_ts = (m_ts + 1) % 65536;
            m_first = 0;
        end
        m_pcq = pc;
    endtask

    task automatic compare_all();
        check("count", count, exp_q.size());
        check("rd_valid", rd_valid, exp_q.size() != 0);
        check("capturing", capturing, m_cap);
        check("done", done, m_done);
        check("halt_stop", halt_stop, m_hs);
        if (exp_q.size() != 0) check("rd_data", rd_data, exp_q[0]);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] p, input logic h, input logic am, input logic rr);
        @(negedge clk);
        pc = p; halt = h; arm = am; rd_ready = rr;
        alures = $urandom; register_out = $urandom;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pcs2 [3];
    logic [15:0] ts6  [3];
    logic [31:0] cur_pc;

    initial begin
        pcs2[0] = 32'h0; pcs2[1] = 32'h4; pcs2[2] = 32'h8;
        ts6[0] = 16'd0;  ts6[1] = 16'd2;  ts6[2] = 16'd5;
        model_reset();

        // reset state
        #12;
        check("rst_count", count, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_capturing", capturing, 0);
        check("rst_done", done, 0);
        check("rst_halt_stop", halt_stop, 0);
        @(negedge clk); rst = 1'b1;

        // asynchronous reset in the middle of a capture holding 5 entries
        step(32'h0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(32'h100 + 32'(i * 4), 0, 0, 0);
        check("pre_rst_count", count, 5);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_capturing", capturing, 0);
        check("async_rst_done", done, 0);
        model_reset();
        @(negedge clk); rst = 1'b1;

        // repeated pc is not a new instruction
        step(32'hFFF0, 0, 1, 0);
        step(32'h0, 0, 0, 0);
        step(32'h4, 0, 0, 0);
        step(32'h4, 0, 0, 0);
        step(32'h8, 0, 0, 0);
        check("dup_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            check("dup_order_pc", rd_data[95:64], pcs2[i]);
            step(32'h8, 0, 0, 1);
        end
        check("dup_drained", count, 0);

        // fill to DEPTH; the 17th pc is dropped
        step(32'h0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step(32'h1000 + 32'(i * 4), 0, 0, 0);
        check("full_count", count, 16);
        check("full_done", done, 1);
        check("full_halt_stop", halt_stop, 0);
        check("full_capturing", capturing, 0);

        // drain oldest-first while DONE
        for (int i = 0; i < 16; i++) begin
            check("drain_pc", rd_data[95:64], 32'h1000 + 32'(i * 4));
            step(32'h2000, 0, 0, 1);
        end
        check("drain_count", count, 0);
        check("drain_done", done, 1);
        check("drain_valid", rd_valid, 0);

        // halt stops capture but its own sample is still recorded
        step(32'h0, 0, 1, 0);
        step(32'h10, 0, 0, 0);
        step(32'h14, 1, 0, 0);
        check("halt_count", count, 2);
        check("halt_done", done, 1);
        check("halt_stop", halt_stop, 1);
        check("halt_last_pc", rd_data[95:64], 32'h10);
        step(32'h18, 0, 0, 0);
        check("halt_no_more", count, 2);

        // simultaneous read and write keep count steady
        step(32'h0, 0, 1, 0);
        step(32'h20, 0, 0, 0);
        step(32'h24, 0, 0, 0);
        step(32'h28, 0, 0, 0);
        step(32'h2C, 0, 0, 1);
        check("rw_count", count, 3);
        check("rw_capturing", capturing, 1);

        // arm wins over a read in the same cycle
        step(32'h30, 0, 1, 1);
        check("arm_clear_count", count, 0);

`ifdef TRACE_TIMESTAMP_EN
        // timestamps follow CAPTURE cycles
        step(32'hA0, 0, 1, 0);
        step(32'hA0, 0, 0, 0);
        step(32'hA0, 0, 0, 0);
        step(32'hB0, 0, 0, 0);
        step(32'hB0, 0, 0, 0);
        step(32'hB0, 0, 0, 0);
        step(32'hC0, 0, 0, 0);
        check("ts_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            check("ts_value", rd_data[111:96], ts6[i]);
            step(32'hC0, 0, 0, 1);
        end
`endif

        // randomized traffic
        cur_pc = 32'h40;
        step(cur_pc, 0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            logic h, am, rr;
            if ($urandom_range(0, 1) == 1) cur_pc = 32'($urandom_range(0, 15)) << 2;
            h  = ($urandom_range(0, 59) == 0);
            am = ($urandom_range(0, 79) == 0);
            rr = ($urandom_range(0, 2) == 0);
            step(cur_pc, h, am, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
